// File: rtl/psi_bitmap_loader_pkg.sv
// Shared types and defaults for the PSI bitmap loader and its AND-tree consumer.
package psi_pkg;

    localparam int PSI_N_PARTIES = 10;
    localparam int PSI_N_BITS    = 10;

    typedef enum logic {LOAD, HOLD} psi_ld_state_t;

    function automatic int flat_pos(input int p, input int b, input int n_bits = PSI_N_BITS);
        return p * n_bits + b;
    endfunction

endpackage

// File: rtl/psi_bitmap_loader_if.sv
// Element-beat input stream plus flat bitmap output handshake of the PSI loader.
interface psi_bitmap_loader_if
    import psi_pkg::*;
#(
    parameter int N_PARTIES = PSI_N_PARTIES,
    parameter int N_BITS    = PSI_N_BITS,
    parameter int PID_W     = $clog2(N_PARTIES),
    parameter int IDX_W     = $clog2(N_BITS + 1)
) ();

    logic                          in_valid;
    logic                          in_ready;
    logic [PID_W-1:0]              in_party;
    logic [IDX_W-1:0]              in_idx;
    logic                          in_last;
    logic [N_PARTIES*N_BITS-1:0]   p_input;
    logic                          out_valid;
    logic                          out_ready;
    logic [N_PARTIES-1:0]          done_mask;

    modport master (
        output in_valid, in_party, in_idx, in_last, out_ready,
        input  in_ready, p_input, out_valid, done_mask
    );

    modport slave (
        input  in_valid, in_party, in_idx, in_last, out_ready,
        output in_ready, p_input, out_valid, done_mask
    );

endinterface

// File: rtl/psi_bitmap_loader_idx_decode.sv
// Element index to one-hot bit; indices at or beyond N_BITS decode to all zeros.
module psi_idx_decode #(
    parameter int N_BITS = 10,
    parameter int IDX_W  = $clog2(N_BITS + 1)
) (
    input  logic [IDX_W-1:0]  i_idx,
    output logic [N_BITS-1:0] o_onehot
);

    always_comb begin
        // NOTE: assign every always_comb output a default first so no path infers a latch.
        o_onehot = '0;
        for (int b = 0; b < N_BITS; b++) begin
            if (i_idx == IDX_W'(b)) o_onehot[b] = 1'b1;
        end
    end

endmodule

// File: rtl/psi_bitmap_loader.sv
// Builds one membership bitmap per party and hands the flat vector to the AND-tree.
// Optional sticky protocol-error output enabled by defining PSI_LOADER_ERR_EN.
module psi_bitmap_loader
    import psi_pkg::*;
#(
    parameter int N_PARTIES = PSI_N_PARTIES,
    parameter int N_BITS    = PSI_N_BITS
) (
    input  logic                clk,
    input  logic                rst,
    psi_bitmap_loader_if.slave  bus
`ifdef PSI_LOADER_ERR_EN
    ,
    output logic                err
`endif
);

    localparam int PID_W = $clog2(N_PARTIES);
    localparam int IDX_W = $clog2(N_BITS + 1);

    psi_ld_state_t                r_state, w_next_state;
    logic [N_PARTIES*N_BITS-1:0]  r_p_input, w_next_p_input;
    logic [N_PARTIES-1:0]         r_done_mask, w_next_done_mask;
    logic [N_PARTIES-1:0]         w_party_sel;
    logic [N_BITS-1:0]            w_onehot;
    logic                         w_accept;
    logic                         w_legal;

    psi_idx_decode #(
        .N_BITS (N_BITS),
        .IDX_W  (IDX_W)
    ) u_idx_decode (
        .i_idx    (bus.in_idx),
        .o_onehot (w_onehot)
    );

    // An out-of-range party id selects no row, which also makes the beat illegal.
    always_comb begin
        w_party_sel = '0;
        for (int p = 0; p < N_PARTIES; p++) begin
            w_party_sel[p] = (bus.in_party == PID_W'(p));
        end
    end

    assign w_accept = bus.in_valid && (r_state == LOAD);
    assign w_legal  = w_accept && (|w_party_sel) && !(|(w_party_sel & r_done_mask));

    always_comb begin
        w_next_state     = r_state;
        w_next_p_input   = r_p_input;
        w_next_done_mask = r_done_mask;
        case (r_state)
            LOAD: begin
                if (w_legal) begin
                    for (int p = 0; p < N_PARTIES; p++) begin
                        if (w_party_sel[p]) begin
                            w_next_p_input[flat_pos(p, 0, N_BITS) +: N_BITS] =
                                r_p_input[flat_pos(p, 0, N_BITS) +: N_BITS] | w_onehot;
                            if (bus.in_last) w_next_done_mask[p] = 1'b1;
                        end
                    end
                    if (&w_next_done_mask) w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    w_next_state     = LOAD;
                    w_next_p_input   = '0;
                    w_next_done_mask = '0;
                end
            end
            default: w_next_state = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state     <= LOAD;
            r_p_input   <= '0;
            r_done_mask <= '0;
        end else begin
            r_state     <= w_next_state;
            r_p_input   <= w_next_p_input;
            r_done_mask <= w_next_done_mask;
        end
    end

    assign bus.in_ready  = (r_state == LOAD);
    assign bus.out_valid = (r_state == HOLD);
    assign bus.p_input   = r_p_input;
    assign bus.done_mask = r_done_mask;

`ifdef PSI_LOADER_ERR_EN
    logic r_err;
    logic w_null;

    assign w_null = ~|w_onehot;

    // Sticky: only reset clears it, a completed handshake does not.
    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (w_accept && (!w_legal || (w_null && !bus.in_last)))
            r_err <= 1'b1;
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_psi_bitmap_loader.sv
// Directed bench for psi_bitmap_loader with hand-computed bitmap expectations.
module tb_psi_bitmap_loader;
    import psi_pkg::*;

    localparam int NP = PSI_N_PARTIES;
    localparam int NB = PSI_N_BITS;

    logic clk;
    logic rst;
`ifdef PSI_LOADER_ERR_EN
    logic err;
`endif

    int n_vec = 0;
    int n_err = 0;

    psi_bitmap_loader_if bus ();

    psi_bitmap_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef PSI_LOADER_ERR_EN
        ,
        .err (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NB-1:0] and_tree(input logic [NP*NB-1:0] v);
        logic [NB-1:0] o;
        o = '1;
        for (int p = 0; p < NP; p++) o &= v[p*NB +: NB];
        return o;
    endfunction

    // One beat per cycle: drive on the falling edge, observe 1 time unit after the rising edge.
    task automatic send(input int p, input int i, input logic last);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_party = 4'(p);
        bus.in_idx   = 4'(i);
        bus.in_last  = last;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL %s_clr_valid: got %b want 0", tag, bus.out_valid); end
        n_vec++; if (bus.p_input !== '0) begin n_err++; $display("FAIL %s_clr_pin: got %h want 0", tag, bus.p_input); end
        n_vec++; if (bus.done_mask !== '0) begin n_err++; $display("FAIL %s_clr_done: got %h want 0", tag, bus.done_mask); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL %s_clr_ready: got %b want 1", tag, bus.in_ready); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_vec++; if (bus.p_input !== '0) begin n_err++; $display("FAIL rst_pin: got %h want 0", bus.p_input); end
        n_vec++; if (bus.done_mask !== '0) begin n_err++; $display("FAIL rst_done: got %h want 0", bus.done_mask); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_full_set();
        for (int p = 0; p < NP; p++) begin
            send(p, 3, 1'b0);
            if (p == NP - 1) begin
                n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL full_early_valid: got %b want 0", bus.out_valid); end
                n_vec++; if (bus.done_mask !== 10'h1FF) begin n_err++; $display("FAIL full_pre_done: got %h want 1ff", bus.done_mask); end
            end
            send(p, 7, 1'b1);
        end
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL full_valid: got %b want 1", bus.out_valid); end
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", bus.in_ready); end
        n_vec++; if (bus.p_input !== {10{10'h088}}) begin n_err++; $display("FAIL full_pin: got %h want %h", bus.p_input, {10{10'h088}}); end
        n_vec++; if (and_tree(bus.p_input) !== 10'h088) begin n_err++; $display("FAIL full_and: got %h want 088", and_tree(bus.p_input)); end
        n_vec++; if (bus.done_mask !== 10'h3FF) begin n_err++; $display("FAIL full_done: got %h want 3ff", bus.done_mask); end
        consume("full");
    endtask

    task automatic test_interleave();
        logic [NP-1:0] exp_done;
        send(9, 3, 1'b0);
        send(0, 3, 1'b0);
        send(9, 7, 1'b1);
        n_vec++; if (bus.done_mask !== 10'h200) begin n_err++; $display("FAIL ilv_done9: got %h want 200", bus.done_mask); end
        send(0, 7, 1'b1);
        n_vec++; if (bus.done_mask !== 10'h201) begin n_err++; $display("FAIL ilv_done0: got %h want 201", bus.done_mask); end
        exp_done = 10'h201;
        for (int p = 1; p < NP - 1; p++) begin
            send(p, 7, 1'b0);
            send(p, 3, 1'b1);
            exp_done[p] = 1'b1;
        end
        n_vec++; if (bus.done_mask !== exp_done) begin n_err++; $display("FAIL ilv_done: got %h want %h", bus.done_mask, exp_done); end
        n_vec++; if (bus.p_input !== {10{10'h088}}) begin n_err++; $display("FAIL ilv_pin: got %h want %h", bus.p_input, {10{10'h088}}); end
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL ilv_valid: got %b want 1", bus.out_valid); end
        consume("ilv");
    endtask

    // Leaves the loader in HOLD with party 4 empty and all others holding element 5.
    task automatic test_empty_party();
        for (int p = 0; p < NP; p++) begin
            if (p == 4) begin
                send(4, 15, 1'b1);
                n_vec++; if (bus.done_mask[4] !== 1'b1) begin n_err++; $display("FAIL empty_done4: got %b want 1", bus.done_mask[4]); end
            end else begin
                send(p, 5, 1'b1);
            end
        end
        n_vec++; if (bus.p_input[49:40] !== 10'h000) begin n_err++; $display("FAIL empty_slice: got %h want 000", bus.p_input[49:40]); end
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL empty_valid: got %b want 1", bus.out_valid); end
`ifdef PSI_LOADER_ERR_EN
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL empty_err: got %b want 0", err); end
`endif
    endtask

    task automatic test_backpressure();
        logic [NP*NB-1:0] exp_pin;
        exp_pin = {{5{10'h020}}, 10'h000, {4{10'h020}}};
        for (int c = 0; c < 5; c++) begin
            send(4, 1, 1'b1);
            n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0", c, bus.in_ready); end
            n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", c, bus.out_valid); end
            n_vec++; if (bus.p_input !== exp_pin) begin n_err++; $display("FAIL bp_pin[%0d]: got %h want %h", c, bus.p_input, exp_pin); end
        end
        consume("bp");
    endtask

    task automatic test_illegal();
        send(12, 2, 1'b0);
        n_vec++; if (bus.p_input !== '0) begin n_err++; $display("FAIL ill_pid_pin: got %h want 0", bus.p_input); end
        n_vec++; if (bus.done_mask !== '0) begin n_err++; $display("FAIL ill_pid_done: got %h want 0", bus.done_mask); end
`ifdef PSI_LOADER_ERR_EN
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL ill_err: got %b want 1", err); end
`endif
        send(2, 4, 1'b1);
        n_vec++; if (bus.p_input !== (100'h1 << 24)) begin n_err++; $display("FAIL ill_legal_pin: got %h want bit24", bus.p_input); end
        send(2, 6, 1'b0);
        n_vec++; if (bus.p_input !== (100'h1 << 24)) begin n_err++; $display("FAIL ill_repeat_pin: got %h want bit24", bus.p_input); end
        n_vec++; if (bus.done_mask !== 10'h004) begin n_err++; $display("FAIL ill_repeat_done: got %h want 004", bus.done_mask); end
`ifdef PSI_LOADER_ERR_EN
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL ill_err_sticky: got %b want 1", err); end
`endif
    endtask

    // Continues the round opened by test_illegal, where party 2 is already done.
    task automatic test_reset_mid_load();
        send(0, 1, 1'b1);
        send(1, 1, 1'b1);
        send(3, 1, 1'b1);
        send(4, 1, 1'b1);
        send(5, 1, 1'b1);
        n_vec++; if (bus.done_mask !== 10'h03F) begin n_err++; $display("FAIL mid_done: got %h want 03f", bus.done_mask); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_vec++; if (bus.p_input !== '0) begin n_err++; $display("FAIL mid_pin: got %h want 0", bus.p_input); end
        n_vec++; if (bus.done_mask !== '0) begin n_err++; $display("FAIL mid_rdone: got %h want 0", bus.done_mask); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b want 1", bus.in_ready); end
`ifdef PSI_LOADER_ERR_EN
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL mid_err: got %b want 0", err); end
`endif
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_party  = '0;
        bus.in_idx    = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_full_set();
        test_interleave();
        test_empty_party();
        test_backpressure();
        test_illegal();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
